row_delay_ctrl: RTL

Streams per-pixel SGM cost vectors into a single-port line RAM (`ram_inference`) and returns, for every accepted pixel, the vector stored at the same column one row earlier. It is read-before-write: each pixel both reads the old value and writes the new value at its column address. Output is tagged with the column and a first-row flag. It sits between the cost-volume stage and the top-to-bottom path aggregator.

---
 rtl/row_delay_ctrl_pkg.sv | 33 +++
 rtl/row_delay_ctrl_if.sv | 42 ++++
 rtl/row_delay_ctrl_ram_inference.sv | 48 ++++
 rtl/row_delay_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/row_delay_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : row_delay_ctrl_pkg
//  Purpose  : Shared defaults for the SGM line-delay path (cost-vector width,
//             row length) and the clog2 helper used to size column addresses.
//             Shared with the top-to-bottom path aggregator.
//  Revision : 1.0  initial release
// ============================================================================
package row_delay_ctrl_pkg;

    localparam int c_DATA_WIDTH_DEFAULT = 256;
    localparam int c_LINE_WIDTH_DEFAULT = 640;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Address width for a RAM of the given depth, never narrower than 1 bit.
    function automatic int addr_bits(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage : row_delay_ctrl_pkg
`default_nettype wire

// File: rtl/row_delay_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : row_delay_ctrl_if
//  Purpose  : Pixel stream in / delayed-row stream out of row_delay_ctrl.
//  Ports    : in_valid/in_ready/in_sof/in_data    - cost-vector input beat
//             out_valid/out_data/out_col/out_first_row - previous-row result
//             sof_err                              - misplaced start-of-frame
//  Modports : master - the producer/consumer around the block
//             slave  - row_delay_ctrl itself
//  Revision : 1.0  initial release
// ============================================================================
interface row_delay_ctrl_if
    import row_delay_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT,
    parameter int LINE_WIDTH = c_LINE_WIDTH_DEFAULT
) ();

    localparam int ADDRESS_BITS = addr_bits(LINE_WIDTH);

    logic                    in_valid;
    logic                    in_ready;
    logic                    in_sof;
    logic [DATA_WIDTH-1:0]   in_data;
    logic                    out_valid;
    logic [DATA_WIDTH-1:0]   out_data;
    logic [ADDRESS_BITS-1:0] out_col;
    logic                    out_first_row;
    logic                    sof_err;

    modport master (
        output in_valid, in_sof, in_data,
        input  in_ready, out_valid, out_data, out_col, out_first_row, sof_err
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output in_ready, out_valid, out_data, out_col, out_first_row, sof_err
    );

endinterface : row_delay_ctrl_if
`default_nettype wire

// File: rtl/row_delay_ctrl_ram_inference.sv
`default_nettype none
// ============================================================================
//  Module   : ram_inference
//  Purpose  : Single-port read-before-write RAM with two output registers.
//             Both the read register and the output register advance only
//             when en=1, so the read data moves in lockstep with the caller's
//             tag pipeline. Contents and output registers are unreset.
//  Ports    : clk  - clock
//             en   - access / pipeline advance
//             we   - write enable (old word is still read out)
//             addr - word address
//             di   - write data
//             dout - read data, two advances after the access
//  Revision : 1.0  initial release
// ============================================================================
module ram_inference
    import row_delay_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH = c_DATA_WIDTH_DEFAULT,
    parameter  int RAM_DEPTH  = c_LINE_WIDTH_DEFAULT,
    localparam int ADDR_BITS  = addr_bits(RAM_DEPTH)
) (
    input  wire logic                  clk,
    input  wire logic                  en,
    input  wire logic                  we,
    input  wire logic [ADDR_BITS-1:0]  addr,
    input  wire logic [DATA_WIDTH-1:0] di,
    output logic      [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] r_mem [RAM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rd;
    logic [DATA_WIDTH-1:0] r_dout;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                r_mem[addr] <= di;
            end
            r_rd   <= r_mem[addr];
            r_dout <= r_rd;
        end
    end

    assign dout = r_dout;

endmodule : ram_inference
`default_nettype wire

// File: rtl/row_delay_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : row_delay_ctrl
//  Purpose  : Line delay for SGM cost vectors. Each accepted pixel is written
//             into a line RAM at its column while the vector stored there one
//             row earlier is read out and returned, tagged with its column
//             and a first-row flag (row 0 has no valid predecessor).
//  Ports    : clk   - clock
//             rst_n - asynchronous active-low reset
//             bus   - row_delay_ctrl_if.slave (stream in, delayed stream out)
//  Revision : 1.0  initial release
// ============================================================================
module row_delay_ctrl
    import row_delay_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH   = c_DATA_WIDTH_DEFAULT,
    parameter  int LINE_WIDTH   = c_LINE_WIDTH_DEFAULT,
    localparam int ADDRESS_BITS = addr_bits(LINE_WIDTH)
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    row_delay_ctrl_if.slave  bus
);

    localparam logic [ADDRESS_BITS-1:0] c_LAST_COL = ADDRESS_BITS'(LINE_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LINE  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    typedef struct packed {
        logic                    valid;
        logic [ADDRESS_BITS-1:0] col;
        logic                    first_row;
    } tag_t;

    state_t                  r_state, w_state_nxt;
    logic [ADDRESS_BITS-1:0] r_col,   w_col_nxt;
    logic                    r_first_row, w_first_row_nxt;
    logic                    r_sof_err,   w_sof_err_nxt;
    tag_t                    r_tag0, r_tag1, w_tag_in;
    logic                    r_en_q;

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_ram_en;
    logic                    w_ram_we;
    logic [ADDRESS_BITS-1:0] w_ram_addr;
    logic [ADDRESS_BITS-1:0] w_col_eff;
    logic                    w_first_row_eff;
    logic [DATA_WIDTH-1:0]   w_ram_dout;

    // FLUSH is the only cycle that refuses input.
    assign w_ready  = (r_state != ST_FLUSH);
    assign w_accept = bus.in_valid & w_ready;

    // A start-of-frame beat always restarts at column 0 as a first-row pixel.
    assign w_col_eff       = bus.in_sof ? '0   : r_col;
    assign w_first_row_eff = bus.in_sof ? 1'b1 : r_first_row;

    always_comb begin
        w_state_nxt     = r_state;
        w_col_nxt       = r_col;
        w_first_row_nxt = r_first_row;
        w_sof_err_nxt   = 1'b0;
        w_ram_en        = 1'b0;
        w_ram_we        = 1'b0;
        w_ram_addr      = '0;
        w_tag_in        = '0;

        case (r_state)
            ST_IDLE: begin
                // Beats without in_sof are swallowed; no RAM access.
                if (w_accept && bus.in_sof) begin
                    w_ram_en        = 1'b1;
                    w_ram_we        = 1'b1;
                    w_ram_addr      = '0;
                    w_tag_in        = '{valid: 1'b1, col: '0, first_row: 1'b1};
                    w_first_row_nxt = 1'b1;
                    if (c_LAST_COL == '0) begin
                        w_col_nxt   = '0;
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_col_nxt   = ADDRESS_BITS'(1);
                        w_state_nxt = ST_LINE;
                    end
                end
            end

            ST_LINE: begin
                if (w_accept) begin
                    w_ram_en        = 1'b1;
                    w_ram_we        = 1'b1;
                    w_ram_addr      = w_col_eff;
                    w_tag_in        = '{valid: 1'b1, col: w_col_eff, first_row: w_first_row_eff};
                    w_first_row_nxt = w_first_row_eff;
                    w_sof_err_nxt   = bus.in_sof & (r_col != '0);
                    if (w_col_eff == c_LAST_COL) begin
                        w_col_nxt   = '0;
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_col_nxt   = w_col_eff + 1'b1;
                    end
                end
            end

            ST_FLUSH: begin
                // Dummy read pushes the line's last pixel out of the RAM
                // pipeline; its bubble tag carries valid=0.
                w_ram_en        = 1'b1;
                w_ram_we        = 1'b0;
                w_ram_addr      = '0;
                w_first_row_nxt = 1'b0;
                w_state_nxt     = ST_LINE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= '0;
            r_first_row <= 1'b0;
            r_sof_err   <= 1'b0;
            r_en_q      <= 1'b0;
            r_tag0      <= '0;
            r_tag1      <= '0;
        end else begin
            r_col       <= w_col_nxt;
            r_first_row <= w_first_row_nxt;
            r_sof_err   <= w_sof_err_nxt;
            r_en_q      <= w_ram_en;
            // Tags shift only with the RAM's output registers.
            if (w_ram_en) begin
                r_tag0 <= w_tag_in;
                r_tag1 <= r_tag0;
            end
        end
    end

    ram_inference #(
        .DATA_WIDTH (DATA_WIDTH),
        .RAM_DEPTH  (LINE_WIDTH)
    ) u_ram (
        .clk  (clk),
        .en   (w_ram_en),
        .we   (w_ram_we),
        .addr (w_ram_addr),
        .di   (bus.in_data),
        .dout (w_ram_dout)
    );

    // The RAM output register only changed on the previous advance, so a
    // result is presented for exactly one cycle after that advance.
    assign bus.in_ready      = w_ready;
    assign bus.out_valid     = r_en_q & r_tag1.valid;
    assign bus.out_data      = w_ram_dout;
    assign bus.out_col       = r_tag1.col;
    assign bus.out_first_row = r_tag1.first_row;
    assign bus.sof_err       = r_sof_err;

endmodule : row_delay_ctrl
`default_nettype wire
